// File: rtl/fa_self_check.sv
// On-board checker for a 1-bit full adder: walks all eight {ai,bi,ci} vectors,
// samples so/co after SETTLE cycles and reports a pass/fail verdict plus error count.
module fa_self_check #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       ai,
  output logic       bi,
  output logic       ci,
  input  logic       so,
  input  logic       co,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] fail_vec,
  output logic       fail_valid
);

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [2:0] v;
  logic [3:0] cnt;
  logic [1:0] exp_sum;
  logic       mismatch;
  logic [3:0] err_next;

  // Handshake: start is a request honoured only in IDLE/DONE; busy covers the
  // whole run and done marks results valid until the next accepted start or rst.
  assign exp_sum  = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
  assign mismatch = (so != exp_sum[0]) || (co != exp_sum[1]);
  assign err_next = err_cnt + {3'b000, mismatch};

  // The adder sees the vector only during a run; idle drive is all-zero.
  assign {ai, bi, ci} = busy ? v : 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      v          <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= WAIT;
            v          <= '0;
            cnt        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) state <= CHECK;
          else                 cnt   <= cnt + 4'd1;
        end
        CHECK: begin
          err_cnt <= err_next;
          if (mismatch && !fail_valid) begin
            fail_vec   <= v;
            fail_valid <= 1'b1;
          end
          // pass uses err_next so the last vector's result is included.
          if (v == 3'd7) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 4'd0);
          end else begin
            v     <= v + 3'd1;
            cnt   <= '0;
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fa_self_check.md
# fa_self_check

Synthesizable stimulus-and-response checker for the 1-bit full adder `fa`. It drives the adder's `ai`/`bi`/`ci` inputs through all 8 input combinations, samples `so`/`co` after a programmable settle time, and compares each result against the expected sum. It runs on the board: the verdict and error count go to LEDs, so the adder can be tested without a simulator.

## Interface
- `SETTLE`, default 2: cycles to wait after applying a vector before sampling the outputs. Legal range is 1..15.
- `clk`  in  1  system clock; every register updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a run. Sampled only in IDLE or DONE.
- `ai`  out  1  drive to the adder's `ai`; equals bit 2 of the current vector.
- `bi`  out  1  drive to the adder's `bi`; equals bit 1 of the current vector.
- `ci`  out  1  drive to the adder's `ci`; equals bit 0 of the current vector.
- `so`  in  1  sum output from the adder under test.
- `co`  in  1  carry output from the adder under test.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  high in DONE; the results are valid.
- `pass`  out  1  high in DONE when `err_cnt` is 0.
- `err_cnt`  out  4  number of mismatching vectors, range 0..8.
- `fail_vec`  out  3  first failing vector `{ai,bi,ci}`; 0 if no vector failed.
- `fail_valid`  out  1  high once at least one mismatch has been recorded.

## Operation
- States:
  - IDLE: reset state.
  - WAIT: settle counter `cnt` is counting.
  - CHECK: outputs are sampled and compared.
  - DONE: results are held.
- Vector register `v[2:0]`. The outputs `{ai,bi,ci}` are the registered value of `v` while `busy` is high, and 0 otherwise.
- Expected result: `{exp_co, exp_so} = ai + bi + ci`, computed as a 2-bit sum.
- Mismatch: `(so != exp_so) || (co != exp_co)`. Each vector counts at most one error, even if both bits are wrong.
- IDLE or DONE with `start` high:
  - Next state is WAIT.
  - Clear `v`, `cnt`, `err_cnt` and `fail_valid`.
  - Clear `fail_vec` to 0.
  - Clear `done` and `pass`.
- WAIT:
  - If `cnt == SETTLE-1`, go to CHECK.
  - Otherwise increment `cnt`.
- CHECK: compare the sampled outputs against the expected values.
  - On mismatch, increment `err_cnt`.
  - On the first mismatch only, load `fail_vec <= v` and set `fail_valid`.
  - If `v == 7`, go to DONE.
  - Otherwise increment `v`, clear `cnt` and go to WAIT.
- DONE:
  - `done = 1`.
  - `pass = (err_cnt == 0)`.
  - `err_cnt`, `fail_vec` and `fail_valid` hold until the next `start` or `rst`.
- `start` is ignored while `busy` is high.
- `start` held high continuously restarts the run on every entry to DONE. DONE is then visible for exactly one cycle.
- Reset values, all zero:
  - `ai`, `bi`, `ci`, `busy`, `done`, `pass`, `err_cnt`, `fail_vec`, `fail_valid`.
  - Internal state returns to IDLE.
- A reset in the middle of a run aborts it. On the next edge all outputs are 0 and the state is IDLE; no partial results are kept.

## Timing
- Notation: edge k is the edge at which `start` is accepted.
- `busy` and the vector-0 drive appear after edge k.
- Each vector takes `SETTLE+1` cycles: `SETTLE` in WAIT, then 1 in CHECK.
- Vector n is sampled at edge `k + (n+1)*(SETTLE+1)`.
- `done` rises, and `busy` falls, after edge `k + 8*(SETTLE+1)`. With the default `SETTLE=2` this is 24 cycles after acceptance.
- The vector changes after each CHECK edge. The adder output therefore has at least `SETTLE` full cycles to settle before it is sampled.
- `err_cnt` and `fail_vec` update on the CHECK edge and are visible in the following cycle.

## Test plan
- Correct `fa` connected, `SETTLE=2`, one-cycle `start` → `done` rises 24 cycles later, `pass=1`, `err_cnt=0`, `fail_valid=0`, `fail_vec=0`.
- Faulty adder with `co` stuck at 0 → the failing vectors are 3, 5, 6 and 7, giving `err_cnt=4`, `fail_vec=3'b011`, `pass=0`.
- Faulty adder with `so` inverted → `err_cnt=8`, `fail_vec=0`, `fail_valid=1`.
- `rst` pulsed while `v=4` → all outputs are 0 on the next cycle. A following `start` runs the full sequence from vector 0.
- `start` pulsed while `busy` is high → no effect on `v` or the timing.
- `start` from DONE after a failing run → results are cleared, and a correct adder now gives `pass=1`.
- `SETTLE=1` → `done` rises 16 cycles after acceptance, and the `{ai,bi,ci}` sequence is 0 through 7, with each vector held for 2 cycles.
